// File: rtl/debounce_toggle_pulse_if.sv
// ============================================================================
// debounce_toggle_pulse_if : button in / debounced status and toggle out
// Rev 1.0
// ============================================================================
`default_nettype none

interface debounce_toggle_pulse_if;
  logic       btn_in;
  logic       enable;
  logic       t_pulse;
  logic       btn_stable;
  logic       busy;
  logic [7:0] press_count;

  modport master (
    output btn_in,
    output enable,
    input  t_pulse,
    input  btn_stable,
    input  busy,
    input  press_count
  );

  modport slave (
    input  btn_in,
    input  enable,
    output t_pulse,
    output btn_stable,
    output busy,
    output press_count
  );
endinterface

`default_nettype wire

// File: rtl/debounce_toggle_pulse.sv
// ============================================================================
// debounce_toggle_pulse : synchronise, debounce and emit one toggle per press
// Rev 1.0
// ============================================================================
`default_nettype none

module debounce_toggle_pulse #(
  parameter int SYNC_STAGES = 2,
  parameter int DB_COUNT    = 16
) (
  input  wire logic          clk,
  input  wire logic          reset,
  debounce_toggle_pulse_if.slave bus
);

  localparam logic [15:0] c_cnt_max = 16'(DB_COUNT - 1);

  typedef enum logic [1:0] {
    IDLE_LOW   = 2'd0,
    CHECK_HIGH = 2'd1,
    HIGH       = 2'd2,
    CHECK_LOW  = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_sync_q;
  state_t                 r_state;
  logic [15:0]            r_cnt;
  logic                   r_t_pulse;
  logic                   r_btn_stable;
  logic                   r_busy;
  logic [7:0]             r_press_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], bus.btn_in};
    end
  end

  assign w_sync_q = r_sync[SYNC_STAGES-1];

  // Outputs are loaded alongside the state so they always reflect the new state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE_LOW;
      r_cnt         <= '0;
      r_t_pulse     <= 1'b0;
      r_btn_stable  <= 1'b0;
      r_busy        <= 1'b0;
      r_press_count <= '0;
    end else begin
      r_t_pulse <= 1'b0;
      case (r_state)
        IDLE_LOW: begin
          if (w_sync_q) begin
            r_state <= CHECK_HIGH;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        CHECK_HIGH: begin
          if (!w_sync_q) begin
            r_state <= IDLE_LOW;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end else if (r_cnt == c_cnt_max) begin
            r_state      <= HIGH;
            r_cnt        <= '0;
            r_busy       <= 1'b0;
            r_btn_stable <= 1'b1;
            if (bus.enable) begin
              r_t_pulse     <= 1'b1;
              r_press_count <= r_press_count + 8'd1;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        HIGH: begin
          if (!w_sync_q) begin
            r_state <= CHECK_LOW;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        CHECK_LOW: begin
          if (w_sync_q) begin
            r_state <= HIGH;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end else if (r_cnt == c_cnt_max) begin
            // Release: level is accepted silently, no toggle request.
            r_state      <= IDLE_LOW;
            r_cnt        <= '0;
            r_busy       <= 1'b0;
            r_btn_stable <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: begin
          r_state      <= IDLE_LOW;
          r_cnt        <= '0;
          r_busy       <= 1'b0;
          r_btn_stable <= 1'b0;
        end
      endcase
    end
  end

  assign bus.t_pulse     = r_t_pulse;
  assign bus.btn_stable  = r_btn_stable;
  assign bus.busy        = r_busy;
  assign bus.press_count = r_press_count;

endmodule

`default_nettype wire

// File: tb/tb_debounce_toggle_pulse.sv
// ============================================================================
// tb_debounce_toggle_pulse : directed bench with a pulse scoreboard per DUT
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_debounce_toggle_pulse;

  localparam int c_sync   = 2;
  localparam int c_db_a   = 16;
  localparam int c_db_b   = 1;
  localparam int c_lat_a  = c_sync + c_db_a + 1;
  localparam int c_lat_b  = c_sync + c_db_b + 1;

  typedef struct {
    int         cyc;
    logic [7:0] cnt;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   checks;
  int   errors;
  int   pulses_a;
  exp_t qa[$];
  exp_t qb[$];

  debounce_toggle_pulse_if ifa ();
  debounce_toggle_pulse_if ifb ();

  debounce_toggle_pulse #(.SYNC_STAGES(c_sync), .DB_COUNT(c_db_a)) u_dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (ifa.slave)
  );

  debounce_toggle_pulse #(.SYNC_STAGES(c_sync), .DB_COUNT(c_db_b)) u_dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (ifb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard consumers: every observed pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset && ifa.t_pulse) begin
      exp_t e;
      checks++;
      assert (qa.size() != 0) else begin
        errors++;
        $error("FAIL a_unexpected_pulse observed_cyc=%0d expected=none", cyc);
      end
      if (qa.size() != 0) begin
        e = qa.pop_front();
        pulses_a++;
        chk("a_pulse_cycle", cyc, e.cyc);
        chk("a_pulse_count", {24'd0, ifa.press_count}, {24'd0, e.cnt});
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && ifb.t_pulse) begin
      exp_t e;
      checks++;
      assert (qb.size() != 0) else begin
        errors++;
        $error("FAIL b_unexpected_pulse observed_cyc=%0d expected=none", cyc);
      end
      if (qb.size() != 0) begin
        e = qb.pop_front();
        chk("b_pulse_cycle", cyc, e.cyc);
        chk("b_pulse_count", {24'd0, ifb.press_count}, {24'd0, e.cnt});
      end
    end
  end

  initial begin
    logic [7:0] model_cnt;
    int         c0;
    checks   = 0;
    errors   = 0;
    pulses_a = 0;
    model_cnt = 8'd0;
    reset      = 1'b1;
    ifa.btn_in = 1'b0;
    ifa.enable = 1'b1;
    ifb.btn_in = 1'b0;
    ifb.enable = 1'b1;
    tick(2);
    chk("rst_t_pulse",  {31'd0, ifa.t_pulse},    32'd0);
    chk("rst_stable",   {31'd0, ifa.btn_stable}, 32'd0);
    chk("rst_busy",     {31'd0, ifa.busy},       32'd0);
    chk("rst_count",    {24'd0, ifa.press_count}, 32'd0);
    reset = 1'b0;
    tick(3);

    // Clean press: busy window, stable rise and pulse timing.
    c0 = cyc;
    ifa.btn_in = 1'b1;
    model_cnt++;
    qa.push_back('{cyc: c0 + c_lat_a, cnt: model_cnt});
    for (int k = 1; k <= c_lat_a; k++) begin
      tick(1);
      chk($sformatf("press_busy_e%0d", k), {31'd0, ifa.busy},
          (k >= c_sync + 1 && k <= c_lat_a - 1) ? 32'd1 : 32'd0);
      chk($sformatf("press_stable_e%0d", k), {31'd0, ifa.btn_stable},
          (k >= c_lat_a) ? 32'd1 : 32'd0);
    end
    tick(3);
    chk("press_count_1", {24'd0, ifa.press_count}, {24'd0, model_cnt});
    ifa.btn_in = 1'b0;
    tick(c_lat_a + 3);
    chk("release_stable", {31'd0, ifa.btn_stable}, 32'd0);
    chk("release_busy",   {31'd0, ifa.busy},       32'd0);
    chk("release_count",  {24'd0, ifa.press_count}, {24'd0, model_cnt});

    // Short burst then held: only the held level qualifies.
    ifa.btn_in = 1'b1;
    tick(10);
    ifa.btn_in = 1'b0;
    tick(3);
    c0 = cyc;
    ifa.btn_in = 1'b1;
    model_cnt++;
    qa.push_back('{cyc: c0 + c_lat_a, cnt: model_cnt});
    tick(c_lat_a + 20);
    chk("bounce_count", {24'd0, ifa.press_count}, {24'd0, model_cnt});
    chk("bounce_q_empty", qa.size(), 32'd0);
    ifa.btn_in = 1'b0;
    tick(c_lat_a + 3);

    // Disabled press: level tracked, no pulse, no count.
    ifa.enable = 1'b0;
    ifa.btn_in = 1'b1;
    tick(c_lat_a + 3);
    chk("dis_stable_hi", {31'd0, ifa.btn_stable}, 32'd1);
    chk("dis_count",     {24'd0, ifa.press_count}, {24'd0, model_cnt});
    ifa.btn_in = 1'b0;
    tick(c_lat_a + 3);
    chk("dis_stable_lo", {31'd0, ifa.btn_stable}, 32'd0);
    chk("dis_count2",    {24'd0, ifa.press_count}, {24'd0, model_cnt});
    ifa.enable = 1'b1;

    // 256 presses from a cleared counter must wrap back to zero.
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    model_cnt = 8'd0;
    pulses_a  = 0;
    tick(2);
    for (int p = 0; p < 256; p++) begin
      c0 = cyc;
      ifa.btn_in = 1'b1;
      model_cnt++;
      qa.push_back('{cyc: c0 + c_lat_a, cnt: model_cnt});
      tick(c_lat_a + 3);
      ifa.btn_in = 1'b0;
      tick(c_lat_a + 3);
    end
    chk("wrap_pulses", pulses_a, 32'd256);
    chk("wrap_count",  {24'd0, ifa.press_count}, 32'd0);

    // Reset mid-qualification discards the press; re-qualifies after release of reset.
    ifa.btn_in = 1'b1;
    tick(c_sync + 1 + 8);
    chk("pre_rst_busy", {31'd0, ifa.busy}, 32'd1);
    reset = 1'b1;
    #1;
    chk("async_busy",   {31'd0, ifa.busy},        32'd0);
    chk("async_stable", {31'd0, ifa.btn_stable},  32'd0);
    chk("async_pulse",  {31'd0, ifa.t_pulse},     32'd0);
    chk("async_count",  {24'd0, ifa.press_count}, 32'd0);
    tick(2);
    c0 = cyc;
    reset = 1'b0;
    model_cnt = 8'd1;
    qa.push_back('{cyc: c0 + c_lat_a, cnt: model_cnt});
    tick(c_lat_a + 5);
    chk("rst_req_count", {24'd0, ifa.press_count}, 32'd1);
    chk("rst_req_q",     qa.size(), 32'd0);
    ifa.btn_in = 1'b0;
    tick(c_lat_a + 3);

    // DB_COUNT=1 instance: short latency and a glitch that must not re-pulse.
    c0 = cyc;
    ifb.btn_in = 1'b1;
    qb.push_back('{cyc: c0 + c_lat_b, cnt: 8'd1});
    tick(c_lat_b + 4);
    chk("b_stable_hi", {31'd0, ifb.btn_stable}, 32'd1);
    ifb.btn_in = 1'b0;
    tick(1);
    ifb.btn_in = 1'b1;
    tick(c_sync);
    chk("b_glitch_busy",   {31'd0, ifb.busy},       32'd1);
    chk("b_glitch_stable", {31'd0, ifb.btn_stable}, 32'd1);
    tick(6);
    chk("b_after_busy",  {31'd0, ifb.busy},        32'd0);
    chk("b_count",       {24'd0, ifb.press_count}, 32'd1);
    chk("b_q_empty",     qb.size(), 32'd0);
    ifb.btn_in = 1'b0;
    tick(8);
    chk("b_stable_lo", {31'd0, ifb.btn_stable}, 32'd0);
    chk("a_q_final",   qa.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/debounce_toggle_pulse.md
DEBOUNCE_TOGGLE_PULSE -- requirements
Module: debounce_toggle_pulse

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops on btn_in; legal range 2..4.
REQ-002 SHALL have parameter DB_COUNT, default 16, consecutive stable synchronized cycles required to accept a level change; legal range 1..65535.
REQ-003 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port btn_in  input  1  raw, asynchronous, bouncing button level.
REQ-006 SHALL have port enable  input  1  when high, accepted presses produce t_pulse and count.
REQ-007 SHALL have port t_pulse  output  1  single-cycle toggle request, intended to drive the T input of the downstream toggle flip-flop.
REQ-008 SHALL have port btn_stable  output  1  debounced button level.
REQ-009 SHALL have port busy  output  1  high while a level change is being qualified.
REQ-010 SHALL have port press_count  output  8  count of accepted, enabled presses.

Function
REQ-011 SHALL pass btn_in through a SYNC_STAGES-deep flop chain; only the last stage (sync_q) is used downstream.
REQ-012 SHALL implement a 4-state FSM: IDLE_LOW, CHECK_HIGH, HIGH, CHECK_LOW, with a 16-bit cycle counter cnt.
REQ-013 In IDLE_LOW, sync_q=1 SHALL move to CHECK_HIGH with cnt<=0; otherwise remain.
REQ-014 In CHECK_HIGH, sync_q=0 SHALL return to IDLE_LOW with cnt<=0 and no pulse.
REQ-015 In CHECK_HIGH, sync_q=1 and cnt==DB_COUNT-1 SHALL move to HIGH; otherwise sync_q=1 SHALL increment cnt.
REQ-016 In HIGH, sync_q=0 SHALL move to CHECK_LOW with cnt<=0; otherwise remain.
REQ-017 In CHECK_LOW, sync_q=1 SHALL return to HIGH with cnt<=0 and no pulse; sync_q=0 and cnt==DB_COUNT-1 SHALL move to IDLE_LOW; otherwise sync_q=0 SHALL increment cnt.
REQ-018 btn_stable SHALL be a registered output, 1 in HIGH and CHECK_LOW, 0 in IDLE_LOW and CHECK_HIGH.
REQ-019 busy SHALL be a registered output, 1 in CHECK_HIGH and CHECK_LOW only.
REQ-020 t_pulse SHALL be registered, high for exactly one cycle, and asserted only on the CHECK_HIGH->HIGH transition when enable=1 at that same edge.
REQ-021 press_count SHALL increment by 1 on the same edge that sets t_pulse and SHALL wrap 255->0.
REQ-022 On the CHECK_LOW->IDLE_LOW transition (release), the block SHALL produce no pulse and no count.
REQ-023 enable=0 SHALL NOT affect FSM, btn_stable or busy; it suppresses only t_pulse and press_count update.
REQ-024 With btn_in held high from a clean low, t_pulse SHALL be high in the cycle following rising edge number SYNC_STAGES+DB_COUNT+1, counting the first edge that samples btn_in=1 as edge 1 (default: after edge 19).
REQ-025 A bounce shorter than DB_COUNT cycles in CHECK_HIGH or CHECK_LOW SHALL restart qualification from cnt=0; the block SHALL NOT produce a second pulse for one held press.
REQ-026 cnt SHALL NOT exceed DB_COUNT-1 and SHALL NOT wrap.

Reset
REQ-027 reset=1 SHALL immediately clear all synchronizer flops, cnt, press_count, t_pulse, btn_stable and busy to 0, and force state to IDLE_LOW.
REQ-028 If reset deasserts while btn_in is held high, the block SHALL re-synchronize and re-qualify the level, producing exactly one t_pulse after the REQ-024 latency.
REQ-029 Reset asserted during CHECK_HIGH SHALL discard the pending press; no pulse and no count SHALL result from it.

Verification
REQ-030 Defaults, enable=1, btn_in 0->1 held: t_pulse high for one cycle after edge 19; btn_stable=1 from the same cycle; press_count=1; busy high over the 16 preceding qualification cycles.
REQ-031 btn_in high 10 cycles, low 3, high held: no pulse for the first burst; exactly one pulse after the final qualification; press_count=1.
REQ-032 enable=0, press then release: btn_stable goes 1 then 0; t_pulse stays 0; press_count stays 0.
REQ-033 256 clean enabled presses: 256 pulses; press_count wraps to 0.
REQ-034 Reset at cnt=8 in CHECK_HIGH with btn_in held: all outputs 0 immediately; after reset deasserts, one pulse after edge 19; press_count=1.
REQ-035 DB_COUNT=1: held press gives t_pulse after edge SYNC_STAGES+2; a 1-cycle glitch during HIGH returns to HIGH without a pulse.
